// File: rtl/loteria_pkg.sv
// loteria_pkg -- shared types and constants for the multi-player lottery.
// Holds the FSM state encoding, the prize codes and the points awarded per prize.
package loteria_pkg;

    typedef enum logic [1:0] {
        SORTEIO = 2'd0,
        APOSTA  = 2'd1,
        AVALIA  = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [1:0] PREMIO_NENHUM = 2'd0;
    localparam logic [1:0] PREMIO_DOIS   = 2'd1;
    localparam logic [1:0] PREMIO_TRES   = 2'd2;
    localparam logic [1:0] PREMIO_TOTAL  = 2'd3;

    localparam int PONTOS_W = 3;

    // Indexed by prize code: none, two hits, three+ hits, all hits.
    localparam logic [3:0][PONTOS_W-1:0] PONTOS_POR_PREMIO = {3'd4, 3'd2, 3'd1, 3'd0};

endpackage

// File: rtl/loteria_avaliador.sv
// loteria_avaliador -- purely combinational ticket evaluator.
// Compares each entered bet digit with the drawn number in the same position,
// counts hits, classifies the prize and, when LOTERIA_SEQUENCIA_EN is defined,
// also reports the longest run of consecutive positional hits.
module loteria_avaliador
    import loteria_pkg::*;
#(
    parameter int NUM_W    = 4,
    parameter int DRAW_LEN = 4,
    parameter int CNT_W    = $clog2(DRAW_LEN + 1)
) (
    input  logic [DRAW_LEN-1:0][NUM_W-1:0] i_draw,
    input  logic [DRAW_LEN-1:0][NUM_W-1:0] i_bet,
    input  logic [CNT_W-1:0]               i_pos,
`ifdef LOTERIA_SEQUENCIA_EN
    output logic [CNT_W-1:0]               o_run,
`endif
    output logic [1:0]                     o_premio
);

    logic [DRAW_LEN-1:0] w_acerto;
    logic [CNT_W-1:0]    w_hits;

    // A position is a hit only if it was actually entered and matches the draw.
    always_comb begin
        w_acerto = '0;
        for (int i = 0; i < DRAW_LEN; i++) begin
            w_acerto[i] = (CNT_W'(i) < i_pos) && (i_bet[i] == i_draw[i]);
        end
    end

    // Count hits and map the count onto the prize code.
    always_comb begin
        w_hits = '0;
        for (int i = 0; i < DRAW_LEN; i++) begin
            w_hits = w_hits + CNT_W'(w_acerto[i]);
        end
        o_premio = PREMIO_NENHUM;
        if (w_hits == CNT_W'(DRAW_LEN)) begin
            o_premio = PREMIO_TOTAL;
        end else if (w_hits >= CNT_W'(3)) begin
            o_premio = PREMIO_TRES;
        end else if (w_hits == CNT_W'(2)) begin
            o_premio = PREMIO_DOIS;
        end
    end

`ifdef LOTERIA_SEQUENCIA_EN
    logic [CNT_W-1:0] w_corrida;

    // Track the current streak of hits and keep the longest one seen.
    always_comb begin
        w_corrida = '0;
        o_run     = '0;
        for (int i = 0; i < DRAW_LEN; i++) begin
            w_corrida = w_acerto[i] ? (w_corrida + CNT_W'(1)) : '0;
            if (w_corrida > o_run) begin
                o_run = w_corrida;
            end
        end
    end
`endif

endmodule

// File: rtl/loteria_multi.sv
// loteria_multi -- multi-player lottery: load a draw, collect one ticket per
// player in turn, score each ticket, and declare the round winner.
// Optional feature: define LOTERIA_SEQUENCIA_EN to award one extra point for a
// ticket holding three or more consecutive positional hits (below full prize).
module loteria_multi
    import loteria_pkg::*;
#(
    parameter int NUM_W     = 4,
    parameter int DRAW_LEN  = 4,
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_W-1:0]             numero,
    input  logic                         carrega,
    input  logic                         insere,
    input  logic                         fim,
    input  logic                         fim_jogo,
    output logic [1:0]                   premio,
    output logic                         premio_valido,
    output logic [$clog2(N_PLAYERS)-1:0] jogador,
    output logic [N_PLAYERS*SCORE_W-1:0] pontos,
    output logic [$clog2(N_PLAYERS)-1:0] vencedor,
    output logic                         empate,
    output logic [1:0]                   estado
);

    localparam int                 CNT_W      = $clog2(DRAW_LEN + 1);
    localparam int                 JOG_W      = $clog2(N_PLAYERS);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [CNT_W-1:0]   ULTIMO_IDX = CNT_W'(DRAW_LEN - 1);
    localparam logic [CNT_W-1:0]   POS_CHEIA  = CNT_W'(DRAW_LEN);
    localparam logic [JOG_W-1:0]   ULTIMO_JOG = JOG_W'(N_PLAYERS - 1);

    estado_t                           r_estado;
    estado_t                           w_proxEstado;
    logic                              w_entraFim;
    logic [CNT_W-1:0]                  r_idx;
    logic [CNT_W-1:0]                  r_pos;
    logic [DRAW_LEN-1:0][NUM_W-1:0]    r_draw;
    logic [DRAW_LEN-1:0][NUM_W-1:0]    r_bet;
    logic                              r_fimPendente;
    logic [JOG_W-1:0]                  r_jogador;
    logic [JOG_W-1:0]                  r_vencedor;
    logic                              r_empate;
    logic [1:0]                        r_premio;
    logic                              r_premioValido;
    logic [N_PLAYERS-1:0][SCORE_W-1:0] r_pontos;
    logic [N_PLAYERS-1:0][SCORE_W-1:0] w_pontosProx;
    logic [SCORE_W-1:0]                w_pontoAtual;
    logic [SCORE_W-1:0]                w_maxPontos;
    logic [SCORE_W:0]                  w_soma;
    logic [PONTOS_W-1:0]               w_ganho;
    logic [1:0]                        w_premio;
    logic [JOG_W-1:0]                  w_vencedor;
    logic                              w_empate;
    logic                              w_insereOk;
`ifdef LOTERIA_SEQUENCIA_EN
    logic [CNT_W-1:0]                  w_run;
`endif

    loteria_avaliador #(
        .NUM_W    (NUM_W),
        .DRAW_LEN (DRAW_LEN),
        .CNT_W    (CNT_W)
    ) u_avaliador (
        .i_draw   (r_draw),
        .i_bet    (r_bet),
        .i_pos    (r_pos),
`ifdef LOTERIA_SEQUENCIA_EN
        .o_run    (w_run),
`endif
        .o_premio (w_premio)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= SORTEIO;
        end else begin
            r_estado <= w_proxEstado;
        end
    end

    // Next-state logic; fim_jogo outranks fim, and a pending ticket is scored before FIM.
    always_comb begin
        w_proxEstado = r_estado;
        unique case (r_estado)
            SORTEIO: if (carrega && (r_idx == ULTIMO_IDX)) w_proxEstado = APOSTA;
            APOSTA: begin
                if (fim_jogo) begin
                    w_proxEstado = (r_pos != '0) ? AVALIA : FIM;
                end else if (fim) begin
                    w_proxEstado = AVALIA;
                end
            end
            AVALIA:  w_proxEstado = r_fimPendente ? FIM : APOSTA;
            FIM:     if (carrega) w_proxEstado = SORTEIO;
            default: w_proxEstado = SORTEIO;
        endcase
        w_entraFim = (w_proxEstado == FIM) && (r_estado != FIM);
        w_insereOk = (r_estado == APOSTA) && insere && !fim && !fim_jogo && (r_pos < POS_CHEIA);
    end

    // Score update for the current player, saturating at the top of the score range.
    always_comb begin
        w_pontoAtual = r_pontos[0];
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (r_jogador == JOG_W'(p)) w_pontoAtual = r_pontos[p];
        end
        w_ganho = PONTOS_POR_PREMIO[w_premio];
`ifdef LOTERIA_SEQUENCIA_EN
        if ((w_run >= CNT_W'(3)) && (w_premio != PREMIO_TOTAL)) begin
            w_ganho = w_ganho + PONTOS_W'(1);
        end
`endif
        w_soma       = {1'b0, w_pontoAtual} + (SCORE_W + 1)'(w_ganho);
        w_pontosProx = r_pontos;
        if (r_estado == AVALIA) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                if (r_jogador == JOG_W'(p)) begin
                    w_pontosProx[p] = (w_soma > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_soma[SCORE_W-1:0];
                end
            end
        end
    end

    // Winner search over the scores as they will be after this cycle (lowest index wins ties).
    always_comb begin
        w_maxPontos = w_pontosProx[0];
        w_vencedor  = '0;
        w_empate    = 1'b0;
        for (int p = 1; p < N_PLAYERS; p++) begin
            if (w_pontosProx[p] > w_maxPontos) begin
                w_maxPontos = w_pontosProx[p];
                w_vencedor  = JOG_W'(p);
            end
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            if ((w_pontosProx[p] == w_maxPontos) && (w_vencedor != JOG_W'(p))) begin
                w_empate = 1'b1;
            end
        end
    end

    // Datapath: draw/bet storage, counters, prize, scores and round result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_idx          <= '0;
            r_pos          <= '0;
            r_draw         <= '0;
            r_bet          <= '0;
            r_fimPendente  <= 1'b0;
            r_jogador      <= '0;
            r_vencedor     <= '0;
            r_empate       <= 1'b0;
            r_premio       <= PREMIO_NENHUM;
            r_premioValido <= 1'b0;
            r_pontos       <= '0;
        end else begin
            r_premioValido <= 1'b0;
            r_pontos       <= w_pontosProx;
            unique case (r_estado)
                SORTEIO: begin
                    if (carrega) begin
                        for (int i = 0; i < DRAW_LEN; i++) begin
                            if (r_idx == CNT_W'(i)) r_draw[i] <= numero;
                        end
                        r_idx <= (r_idx == ULTIMO_IDX) ? '0 : (r_idx + CNT_W'(1));
                    end
                end
                APOSTA: begin
                    if (fim_jogo && (r_pos != '0)) begin
                        r_fimPendente <= 1'b1;
                    end
                    if (w_insereOk) begin
                        for (int i = 0; i < DRAW_LEN; i++) begin
                            if (r_pos == CNT_W'(i)) r_bet[i] <= numero;
                        end
                        r_pos <= r_pos + CNT_W'(1);
                    end
                end
                AVALIA: begin
                    r_premio       <= w_premio;
                    r_premioValido <= 1'b1;
                    r_pos          <= '0;
                    r_fimPendente  <= 1'b0;
                    r_jogador      <= (r_jogador == ULTIMO_JOG) ? '0 : (r_jogador + JOG_W'(1));
                end
                FIM: begin
                    if (carrega) begin
                        r_draw[0] <= numero;
                        r_idx     <= CNT_W'(1);
                        r_jogador <= '0;
                    end
                end
                default: ;
            endcase
            if (w_entraFim) begin
                r_vencedor <= w_vencedor;
                r_empate   <= w_empate;
            end
        end
    end

    assign premio        = r_premio;
    assign premio_valido = r_premioValido;
    assign jogador       = r_jogador;
    assign pontos        = r_pontos;
    assign vencedor      = r_vencedor;
    assign empate        = r_empate;
    assign estado        = r_estado;

endmodule

// File: doc/loteria_multi.md
LOTERIA_MULTI -- requirements
Module: loteria_multi

Interface
REQ-001 SHALL have parameter NUM_W, default 4, width of each drawn/bet number.
REQ-002 SHALL have parameter DRAW_LEN, default 4, numbers per draw and per ticket.
REQ-003 SHALL have parameter N_PLAYERS, default 2, player count (minimum 2).
REQ-004 SHALL have parameter SCORE_W, default 5, accumulated-score width per player.
REQ-005 SHALL have port clock  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port numero  in  NUM_W  number being loaded or bet.
REQ-008 SHALL have port carrega  in  1  load numero as next drawn number.
REQ-009 SHALL have port insere  in  1  enter numero as next bet digit of the current player.
REQ-010 SHALL have port fim  in  1  close the current player's ticket.
REQ-011 SHALL have port fim_jogo  in  1  close the round.
REQ-012 SHALL have port premio  out  2  prize of the last evaluated ticket (0 none, 1 two hits, 2 three+ hits, 3 all hits).
REQ-013 SHALL have port premio_valido  out  1  one-cycle pulse when premio updates.
REQ-014 SHALL have port jogador  out  clog2(N_PLAYERS)  current player index.
REQ-015 SHALL have port pontos  out  N_PLAYERS*SCORE_W  packed scores, player 0 in the LSBs.
REQ-016 SHALL have ports vencedor  out  clog2(N_PLAYERS)  and  empate  out  1  for round result.
REQ-017 SHALL have port estado  out  2  current FSM state.

Function
REQ-018 FSM states: SORTEIO, APOSTA, AVALIA, FIM; all outputs registered.
REQ-019 SORTEIO: each carrega cycle stores numero into draw[idx] and increments idx; the cycle of the DRAW_LEN-th load transitions to APOSTA with idx=0.
REQ-020 APOSTA: each insere cycle stores numero into bet[pos] and increments pos; insere with pos==DRAW_LEN is ignored.
REQ-021 A hit is bet[i]==draw[i] for i<pos; positions never entered count as misses.
REQ-022 premio: 3 if hits==DRAW_LEN, 2 if hits>=3, 1 if hits==2, else 0.
REQ-023 fim in APOSTA goes to AVALIA; one cycle later premio and premio_valido are set, pontos[jogador] is increased by 0/1/2/4 for premio 0/1/2/3, and pos is cleared.
REQ-024 After AVALIA, jogador increments, wrapping N_PLAYERS-1 -> 0, and the FSM returns to APOSTA.
REQ-025 Score addition SHALL saturate at 2^SCORE_W-1.
REQ-026 Priority in the same cycle is fim_jogo > fim > insere; carrega is ignored outside SORTEIO and FIM.
REQ-027 fim_jogo with pos>0 SHALL evaluate the pending ticket via AVALIA, then enter FIM; with pos==0 it enters FIM directly.
REQ-028 On FIM entry: vencedor = lowest index holding the maximum score; empate=1 if two or more players share the maximum.
REQ-029 A carrega in FIM starts a new round: stores draw[0] and sets idx=1, jogador=0, SORTEIO.
REQ-030 Scores are kept across rounds.

Reset
REQ-031 reset low SHALL immediately force SORTEIO, idx=pos=0, jogador=0, pontos=0, premio=0, premio_valido=0, vencedor=0, empate=0, and clear draw and bet registers.
REQ-032 Reset mid-ticket discards all entered digits with no score change.

Configuration
REQ-033 With LOTERIA_SEQUENCIA_EN defined, a ticket with three or more consecutive positional hits and premio<3 SHALL earn one extra point; premio is unchanged.
REQ-034 Without LOTERIA_SEQUENCIA_EN there is no run logic, and points follow REQ-023 only.

Structure
REQ-035 Package loteria_pkg SHALL hold the state enum, premio encoding constants and the points-per-premio table.
REQ-036 Sub-module loteria_avaliador SHALL compute hits, the longest run and premio combinationally from draw, bet and pos.

Verification
REQ-037 Reset: assert reset low mid-APOSTA -> all outputs 0, estado=SORTEIO.
REQ-038 Load 0,3,8,2; player 0 bets 0,3,8,2 + fim -> premio=3, premio_valido pulse, pontos[0]=4, jogador=1.
REQ-039 Player 1 bets 0,3,8,5 + fim -> premio=2; pontos[1]=3 with LOTERIA_SEQUENCIA_EN, 2 without; player bets 0,7,8,2 -> premio=2, +2 in both builds.
REQ-040 Ticket 1,3 only + fim -> premio=0; five insere with 0,3,8,2,9 -> fifth ignored, premio=3.
REQ-041 Saturation: repeated premio-3 tickets for player 0 -> pontos[0] stops at 31.
REQ-042 Tie scenario:
- fim_jogo with pending digits -> AVALIA, then FIM.
- Scores 4/4 -> vencedor=0, empate=1.
- Next carrega -> SORTEIO with idx=1.
